cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
- Datapath that consumes the control word from controller_verilog and returns `opcode`, `Distination`, `carryFlag` and `zeroFlag` to it.
- Holds PC, IR, MDR, accumulator A, the ALU result register and the flag registers.
- Drives a single-port synchronous RAM through a registered address/read/write interface.
- One instruction word: [15:11] opcode, [10] Distination, [9:0] address/immediate.

Parameters:
- DATA_W, 16, data/instruction word width; opcode and Distination fields occupy the top 6 bits.
- ADDR_W, 10, address field and PC width; must be no greater than DATA_W-6.
- RD_LAT, 1, RAM read latency in cycles (1 or 2).

Ports:
- clk  in  1  system clock
- Reset_in  in  1  synchronous active-high reset
- ALU_MUX  in  1  ALU B source: 0=MDR, 1=zero-extended IR[9:0]
- ALU_OP  in  4  ALU operation (encoding in package)
- ALU_EN  in  1  ALU_OUT <= ALU result
- PC_INC  in  1  PC <= PC+1
- PC_LOAD  in  1  PC <= IR[ADDR_W-1:0]
- IR_WR_SIGNAL  in  1  IR <= mem_rdata
- RAM_RD  in  1  issue RAM read
- RAM_WR  in  1  issue RAM write of ALU_OUT
- RAM_MUX  in  1  RAM address: 0=PC, 1=IR address field
- FLAG_WR_SIGNAL  in  1  latch ALU carry/zero
- MDR_WR_SIGNAL  in  1  MDR <= mem_rdata
- A_WR_SIGNAL  in  1  A <= ALU_OUT
- opcode  out  5  IR[15:11]
- Distination  out  1  IR[10]
- carryFlag  out  1  carry flag register
- zeroFlag  out  1  zero flag register
- mem_addr  out  ADDR_W  registered RAM address
- mem_rd  out  1  registered read strobe
- mem_wr  out  1  registered write strobe
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after mem_rd
- rdata_valid  out  1  pulses in the cycle mem_rdata is valid

Behaviour:
- Reset: every register and output is 0, including PC, IR, MDR, A, ALU_OUT, flags, mem_*, rdata_valid and the read-latency shift register. Reset aborts any in-flight read; its data is never flagged valid.
- ALU is combinational on A and B; B is selected by ALU_MUX.
- ALU_OP encoding: 0 ADD, 1 SUB (A-B, carry=borrow), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 INC A, 7 DEC A, 8 PASS B, 9 PASS A, 10 SHL A (carry=msb out), 11 SHR A (carry=lsb out).
- Codes 12-15 behave as PASS A with carry 0.
- Logic and pass ops produce carry 0.
- zero = (result == 0). Arithmetic wraps modulo 2^DATA_W.
- Registers update on the clock edge when their enable is high. A read-modify of the same register in one cycle uses the pre-edge value.
- PC: PC_LOAD has priority over PC_INC when both are high. PC wraps from 2^ADDR_W-1 to 0.
- RAM request: mem_addr, mem_rd, mem_wr and mem_wdata (= ALU_OUT) are registered one cycle after RAM_RD/RAM_WR.
- RAM_RD and RAM_WR both high: the write wins and no read is issued.
- A read asserts rdata_valid exactly RD_LAT cycles after mem_rd.
- IR_WR_SIGNAL and MDR_WR_SIGNAL capture mem_rdata regardless of rdata_valid; the controller owns the timing. Both high loads both registers.
- Back-to-back reads are pipelined, one per cycle; the valid shift register tracks each read independently.
- FLAG_WR_SIGNAL latches the carry/zero of the current-cycle combinational ALU result, independent of ALU_EN.
- opcode and Distination follow IR combinationally, so they change the cycle after IR_WR_SIGNAL.

Optional Feature:
- Macro DP_OVF_FLAG_EN.
- Defined: adds an output overflowFlag (1 bit), the signed overflow for ADD/SUB/INC/DEC and 0 for all other ops. It is latched with FLAG_WR_SIGNAL and resets to 0.
- Undefined: no overflowFlag port and no overflow logic; all other behaviour is identical.

Decomposition:
- Package cpu_pkg holds:
  - ALU_OP localparams (ALU_ADD … ALU_SHR)
  - instruction field positions (OPC_HI/LO, DST_BIT, ADDR_HI/LO)
  - the opcode constants shared with the controller
- One sub-module, cpu_alu: combinational; inputs a, b, op; outputs result, carry, zero (plus ovf under the macro).

Test Plan:
- Fetch: reset, RAM[0]=16'h4800, then RAM_RD=1, RAM_MUX=0 → mem_rd at cycle+1 with mem_addr=0. After the valid pulse, IR_WR_SIGNAL=1 → opcode=5'b01001, Distination=0.
- ADD with carry: A=16'hFFFF, MDR=16'h0001, ALU_OP=0, ALU_MUX=0, ALU_EN and FLAG_WR_SIGNAL → ALU_OUT=0, carryFlag=1, zeroFlag=1. Then A_WR_SIGNAL → A=0.
- Jump priority: IR[9:0]=10'h155, PC_LOAD=1 and PC_INC=1 together → PC=10'h155. Also PC=10'h3FF with PC_INC → PC=0.
- Memory write: ALU_OUT=16'h1234, RAM_MUX=1, IR address 10'h020, RAM_WR=1 with RAM_RD=1 → mem_wr=1, mem_rd=0, mem_addr=10'h020, mem_wdata=16'h1234.
- Reset mid-read: RAM_RD at cycle n, Reset_in at cycle n+1 → rdata_valid never asserts and all registers read 0.
- With DP_OVF_FLAG_EN: A=16'h7FFF, INC A, FLAG_WR_SIGNAL → overflowFlag=1, carryFlag=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: ALU operation codes, instruction
// field layout and the opcode values the controller decodes.
package cpu_pkg;

    localparam int OPC_W   = 5;
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 11;
    localparam int DST_BIT = 10;
    localparam int ADDR_HI = 9;
    localparam int ADDR_LO = 0;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOT  = 4'd5;
    localparam logic [3:0] ALU_INC  = 4'd6;
    localparam logic [3:0] ALU_DEC  = 4'd7;
    localparam logic [3:0] ALU_PASB = 4'd8;
    localparam logic [3:0] ALU_PASA = 4'd9;
    localparam logic [3:0] ALU_SHL  = 4'd10;
    localparam logic [3:0] ALU_SHR  = 4'd11;

    localparam logic [OPC_W-1:0] OPC_NOP = 5'd0;
    localparam logic [OPC_W-1:0] OPC_LDA = 5'd1;
    localparam logic [OPC_W-1:0] OPC_STA = 5'd2;
    localparam logic [OPC_W-1:0] OPC_ADD = 5'd3;
    localparam logic [OPC_W-1:0] OPC_SUB = 5'd4;
    localparam logic [OPC_W-1:0] OPC_AND = 5'd5;
    localparam logic [OPC_W-1:0] OPC_OR  = 5'd6;
    localparam logic [OPC_W-1:0] OPC_JMP = 5'd9;
    localparam logic [OPC_W-1:0] OPC_JZ  = 5'd10;
    localparam logic [OPC_W-1:0] OPC_JC  = 5'd11;
    localparam logic [OPC_W-1:0] OPC_HLT = 5'd31;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: result/carry/zero for A op B.
// DP_OVF_FLAG_EN adds the signed-overflow output ovf.
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              carry,
`ifdef DP_OVF_FLAG_EN
    output logic              ovf,
`endif
    output logic              zero
);

    localparam int M = DATA_W - 1;

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = '0;
        result = a;
        carry  = 1'b0;
        unique case (op)
            ALU_ADD: begin
                sum    = {1'b0, a} + {1'b0, b};
                result = sum[M:0];
                carry  = sum[DATA_W];
            end
            // Top bit of the widened difference is the borrow
            ALU_SUB: begin
                sum    = {1'b0, a} - {1'b0, b};
                result = sum[M:0];
                carry  = sum[DATA_W];
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOT:  result = ~a;
            ALU_INC: begin
                sum    = {1'b0, a} + (DATA_W+1)'(1);
                result = sum[M:0];
                carry  = sum[DATA_W];
            end
            ALU_DEC: begin
                sum    = {1'b0, a} - (DATA_W+1)'(1);
                result = sum[M:0];
                carry  = sum[DATA_W];
            end
            ALU_PASB: result = b;
            ALU_SHL: begin
                result = {a[M-1:0], 1'b0};
                carry  = a[M];
            end
            ALU_SHR: begin
                result = {1'b0, a[M:1]};
                carry  = a[0];
            end
            default:  result = a;
        endcase
    end

    assign zero = (result == '0);

`ifdef DP_OVF_FLAG_EN
    always_comb begin
        ovf = 1'b0;
        unique case (op)
            ALU_ADD: ovf = (a[M] == b[M]) && (result[M] != a[M]);
            ALU_SUB: ovf = (a[M] != b[M]) && (result[M] != a[M]);
            ALU_INC: ovf = ~a[M] & result[M];
            ALU_DEC: ovf = a[M] & ~result[M];
            default: ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: PC/IR/MDR/A/ALU_OUT/flags plus a registered RAM port.
// DP_OVF_FLAG_EN adds the overflowFlag output latched alongside carry/zero.
module cpu_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              Reset_in,
    input  logic              ALU_MUX,
    input  logic [3:0]        ALU_OP,
    input  logic              ALU_EN,
    input  logic              PC_INC,
    input  logic              PC_LOAD,
    input  logic              IR_WR_SIGNAL,
    input  logic              RAM_RD,
    input  logic              RAM_WR,
    input  logic              RAM_MUX,
    input  logic              FLAG_WR_SIGNAL,
    input  logic              MDR_WR_SIGNAL,
    input  logic              A_WR_SIGNAL,
    output logic [4:0]        opcode,
    output logic              Distination,
    output logic              carryFlag,
    output logic              zeroFlag,
`ifdef DP_OVF_FLAG_EN
    output logic              overflowFlag,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              rdata_valid
);

    logic [ADDR_W-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] ir_q, ir_d, mdr_q, mdr_d, a_q, a_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d, mem_wdata_q, mem_wdata_d;
    logic              carry_q, carry_d, zero_q, zero_d;
    logic              mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [RD_LAT-1:0] rd_sr_q, rd_sr_d;

    logic [DATA_W-1:0] alu_b, alu_res;
    logic              alu_carry, alu_zero;
`ifdef DP_OVF_FLAG_EN
    logic              ovf_q, ovf_d, alu_ovf;
`endif

    assign alu_b = ALU_MUX ? DATA_W'(ir_q[ADDR_W-1:0]) : mdr_q;

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_q),
        .b      (alu_b),
        .op     (ALU_OP),
        .result (alu_res),
        .carry  (alu_carry),
`ifdef DP_OVF_FLAG_EN
        .ovf    (alu_ovf),
`endif
        .zero   (alu_zero)
    );

    always_comb begin
        pc_d = pc_q;
        if (PC_LOAD)     pc_d = ir_q[ADDR_W-1:0];
        else if (PC_INC) pc_d = pc_q + ADDR_W'(1);
        ir_d      = IR_WR_SIGNAL  ? mem_rdata : ir_q;
        mdr_d     = MDR_WR_SIGNAL ? mem_rdata : mdr_q;
        a_d       = A_WR_SIGNAL   ? alu_out_q : a_q;
        alu_out_d = ALU_EN        ? alu_res   : alu_out_q;
        carry_d   = FLAG_WR_SIGNAL ? alu_carry : carry_q;
        zero_d    = FLAG_WR_SIGNAL ? alu_zero  : zero_q;
`ifdef DP_OVF_FLAG_EN
        ovf_d     = FLAG_WR_SIGNAL ? alu_ovf   : ovf_q;
`endif
        // A write request suppresses a simultaneous read
        mem_wr_d    = RAM_WR;
        mem_rd_d    = RAM_RD & ~RAM_WR;
        mem_addr_d  = (RAM_RD | RAM_WR) ? (RAM_MUX ? ir_q[ADDR_W-1:0] : pc_q) : mem_addr_q;
        mem_wdata_d = RAM_WR ? alu_out_q : mem_wdata_q;
        rd_sr_d     = RD_LAT'({rd_sr_q, mem_rd_q});
    end

    always_ff @(posedge clk) begin
        if (Reset_in) begin
            pc_q        <= '0;
            ir_q        <= '0;
            mdr_q       <= '0;
            a_q         <= '0;
            alu_out_q   <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            rd_sr_q     <= '0;
`ifdef DP_OVF_FLAG_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            mdr_q       <= mdr_d;
            a_q         <= a_d;
            alu_out_q   <= alu_out_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_sr_q     <= rd_sr_d;
`ifdef DP_OVF_FLAG_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign opcode      = ir_q[DATA_W-1 -: OPC_W];
    assign Distination = ir_q[DATA_W-1-OPC_W];
    assign carryFlag   = carry_q;
    assign zeroFlag    = zero_q;
`ifdef DP_OVF_FLAG_EN
    assign overflowFlag = ovf_q;
`endif
    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;
    assign mem_wdata   = mem_wdata_q;
    assign rdata_valid = rd_sr_q[RD_LAT-1];

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath; covers the overflow flag when DP_OVF_FLAG_EN is defined.
module tb_cpu_datapath;

    logic        clk = 1'b0;
    logic        Reset_in;
    logic        ALU_MUX, ALU_EN, PC_INC, PC_LOAD, IR_WR_SIGNAL;
    logic [3:0]  ALU_OP;
    logic        RAM_RD, RAM_WR, RAM_MUX, FLAG_WR_SIGNAL, MDR_WR_SIGNAL, A_WR_SIGNAL;
    logic [4:0]  opcode;
    logic        Distination, carryFlag, zeroFlag;
`ifdef DP_OVF_FLAG_EN
    logic        overflowFlag;
`endif
    logic [9:0]  mem_addr;
    logic        mem_rd, mem_wr, rdata_valid;
    logic [15:0] mem_wdata, mem_rdata;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    cpu_datapath #(.DATA_W(16), .ADDR_W(10), .RD_LAT(1)) dut (
        .clk            (clk),
        .Reset_in       (Reset_in),
        .ALU_MUX        (ALU_MUX),
        .ALU_OP         (ALU_OP),
        .ALU_EN         (ALU_EN),
        .PC_INC         (PC_INC),
        .PC_LOAD        (PC_LOAD),
        .IR_WR_SIGNAL   (IR_WR_SIGNAL),
        .RAM_RD         (RAM_RD),
        .RAM_WR         (RAM_WR),
        .RAM_MUX        (RAM_MUX),
        .FLAG_WR_SIGNAL (FLAG_WR_SIGNAL),
        .MDR_WR_SIGNAL  (MDR_WR_SIGNAL),
        .A_WR_SIGNAL    (A_WR_SIGNAL),
        .opcode         (opcode),
        .Distination    (Distination),
        .carryFlag      (carryFlag),
        .zeroFlag       (zeroFlag),
`ifdef DP_OVF_FLAG_EN
        .overflowFlag   (overflowFlag),
`endif
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .rdata_valid    (rdata_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ALU_MUX = 0; ALU_OP = 4'd0; ALU_EN = 0; PC_INC = 0; PC_LOAD = 0;
        IR_WR_SIGNAL = 0; RAM_RD = 0; RAM_WR = 0; RAM_MUX = 0;
        FLAG_WR_SIGNAL = 0; MDR_WR_SIGNAL = 0; A_WR_SIGNAL = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        Reset_in  = 1;
        mem_rdata = 16'hA5A5;
        tick(); tick();
        chk("rst_opcode", opcode, 0);
        chk("rst_dst", Distination, 0);
        chk("rst_carry", carryFlag, 0);
        chk("rst_zero", zeroFlag, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_rd", mem_rd, 0);
        chk("rst_wr", mem_wr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_valid", rdata_valid, 0);
`ifdef DP_OVF_FLAG_EN
        chk("rst_ovf", overflowFlag, 0);
`endif
        Reset_in = 0;

        // Fetch from address 0
        RAM_RD = 1; RAM_MUX = 0; tick(); idle();
        chk("fetch_rd", mem_rd, 1);
        chk("fetch_addr", mem_addr, 0);
        chk("fetch_valid_early", rdata_valid, 0);
        mem_rdata = 16'h4800; tick();
        chk("fetch_valid", rdata_valid, 1);
        chk("fetch_rd_drop", mem_rd, 0);
        IR_WR_SIGNAL = 1; tick(); idle();
        chk("fetch_opcode", opcode, 5'b01001);
        chk("fetch_dst", Distination, 0);
        chk("fetch_valid_gone", rdata_valid, 0);

        // MDR=1, A=FFFF via NOT of reset A
        mem_rdata = 16'h0001; MDR_WR_SIGNAL = 1; tick(); idle();
        ALU_OP = 4'd5; ALU_EN = 1; FLAG_WR_SIGNAL = 1; tick(); idle();
        chk("not_carry", carryFlag, 0);
        chk("not_zero", zeroFlag, 0);
        A_WR_SIGNAL = 1; RAM_WR = 1; tick(); idle();
        chk("not_wr", mem_wr, 1);
        chk("not_wdata", mem_wdata, 16'hFFFF);

        // ADD FFFF + 0001
        ALU_OP = 4'd0; ALU_EN = 1; FLAG_WR_SIGNAL = 1; tick(); idle();
        chk("add_carry", carryFlag, 1);
        chk("add_zero", zeroFlag, 1);
        A_WR_SIGNAL = 1; RAM_WR = 1; tick(); idle();
        chk("add_wdata", mem_wdata, 16'h0000);
        // SUB 0 - 1 with ALU_EN low: flags still latch
        ALU_OP = 4'd1; FLAG_WR_SIGNAL = 1; tick(); idle();
        chk("sub_borrow", carryFlag, 1);
        chk("sub_zero", zeroFlag, 0);
        ALU_OP = 4'd9; FLAG_WR_SIGNAL = 1; tick(); idle();
        chk("a_is_zero", zeroFlag, 1);
        chk("pasa_carry", carryFlag, 0);

        // Jump priority and PC wrap
        mem_rdata = 16'hFD55; IR_WR_SIGNAL = 1; tick(); idle();
        chk("jmp_opcode", opcode, 5'h1F);
        chk("jmp_dst", Distination, 1);
        PC_LOAD = 1; PC_INC = 1; tick(); idle();
        RAM_RD = 1; tick(); idle();
        chk("jmp_pc", mem_addr, 10'h155);
        mem_rdata = 16'h03FF; IR_WR_SIGNAL = 1; tick(); idle();
        PC_LOAD = 1; tick(); idle();
        PC_INC = 1; RAM_RD = 1; tick(); idle();
        chk("pc_pre_inc", mem_addr, 10'h3FF);
        RAM_RD = 1; tick(); idle();
        chk("pc_wrap", mem_addr, 10'h000);

        // Immediate B operand
        ALU_OP = 4'd8; ALU_MUX = 1; ALU_EN = 1; tick(); idle();
        RAM_WR = 1; tick(); idle();
        chk("imm_wdata", mem_wdata, 16'h03FF);

        // Memory write wins over read
        mem_rdata = 16'h0020; IR_WR_SIGNAL = 1; tick(); idle();
        mem_rdata = 16'h1234; MDR_WR_SIGNAL = 1; tick(); idle();
        ALU_OP = 4'd8; ALU_EN = 1; tick(); idle();
        RAM_WR = 1; RAM_RD = 1; RAM_MUX = 1; tick(); idle();
        chk("wr_wr", mem_wr, 1);
        chk("wr_rd", mem_rd, 0);
        chk("wr_addr", mem_addr, 10'h020);
        chk("wr_wdata", mem_wdata, 16'h1234);
        tick();
        chk("wr_no_valid", rdata_valid, 0);
        chk("wr_drop", mem_wr, 0);

        // Back-to-back reads
        RAM_RD = 1; tick();
        chk("b2b_rd0", mem_rd, 1);
        chk("b2b_v0", rdata_valid, 0);
        tick(); idle();
        chk("b2b_rd1", mem_rd, 1);
        chk("b2b_v1", rdata_valid, 1);
        tick();
        chk("b2b_rd2", mem_rd, 0);
        chk("b2b_v2", rdata_valid, 1);
        tick();
        chk("b2b_v3", rdata_valid, 0);

        // Reset aborts an in-flight read
        RAM_RD = 1; RAM_MUX = 1; tick(); idle();
        chk("mid_rd", mem_rd, 1);
        chk("mid_addr", mem_addr, 10'h020);
        Reset_in = 1; tick();
        chk("mid_valid", rdata_valid, 0);
        chk("mid_rd_clr", mem_rd, 0);
        chk("mid_addr_clr", mem_addr, 0);
        chk("mid_wdata_clr", mem_wdata, 0);
        chk("mid_zero_clr", zeroFlag, 0);
        Reset_in = 0; tick();
        chk("mid_valid2", rdata_valid, 0);
        ALU_OP = 4'd0; FLAG_WR_SIGNAL = 1; tick(); idle();
        chk("mid_a_mdr_zero", zeroFlag, 1);

        // A=7FFF then INC / SHR
        mem_rdata = 16'h7FFF; MDR_WR_SIGNAL = 1; tick(); idle();
        ALU_OP = 4'd8; ALU_EN = 1; tick(); idle();
        A_WR_SIGNAL = 1; tick(); idle();
        ALU_OP = 4'd6; ALU_EN = 1; FLAG_WR_SIGNAL = 1; tick(); idle();
        chk("inc_carry", carryFlag, 0);
        chk("inc_zero", zeroFlag, 0);
`ifdef DP_OVF_FLAG_EN
        chk("inc_ovf", overflowFlag, 1);
`endif
        RAM_WR = 1; tick(); idle();
        chk("inc_wdata", mem_wdata, 16'h8000);
        ALU_OP = 4'd11; FLAG_WR_SIGNAL = 1; tick(); idle();
        chk("shr_carry", carryFlag, 1);
        chk("shr_zero", zeroFlag, 0);
`ifdef DP_OVF_FLAG_EN
        chk("shr_ovf", overflowFlag, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
